// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, iterator modes
// and the iteration counter width helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_t;

    // Counter must hold 0..width-1 without wrapping.
    function automatic int CNT_W(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational step of the iterative datapath: shift-add multiply or
// restoring divide over the {acc, shreg} register pair.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_mode_t           i_mode,
    input  logic [WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]   i_shreg,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [WIDTH-1:0]   o_acc_next,
    output logic [WIDTH-1:0]   o_shreg_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Multiply: add multiplicand when the current multiplier bit is set, then shift the
    // whole {acc, shreg} pair right so the product builds up from the bottom.
    assign w_sum = i_shreg[0] ? ({1'b0, i_acc} + {1'b0, i_opnd}) : {1'b0, i_acc};

    // Divide: shift the next dividend bit into the remainder; the difference only matters
    // when it is non-negative, and then it always fits in WIDTH bits.
    assign w_shifted = {i_acc, i_shreg[WIDTH-1]};
    assign w_ge      = (w_shifted >= {1'b0, i_opnd});
    assign w_sub     = w_shifted[WIDTH-1:0] - i_opnd;

    always_comb begin
        o_acc_next   = i_acc;
        o_shreg_next = i_shreg;
        if (i_mode == MD_MUL) begin
            o_acc_next   = w_sum[WIDTH:1];
            o_shreg_next = {w_sum[0], i_shreg[WIDTH-1:1]};
        end else begin
            o_acc_next   = w_ge ? w_sub : w_shifted[WIDTH-1:0];
            o_shreg_next = {i_shreg[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS EX-stage ALU: single-cycle logic/arithmetic/compare ops plus
// iterative unsigned multiply and divide, with a start/busy/done handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             div0
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_opnd;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;
    logic             r_div0;

    logic [WIDTH-1:0] w_simple;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_shreg_next;
    md_mode_t         w_mode;

    // Single-cycle result, taken straight from the live inputs on the accepting edge.
    always_comb begin
        w_simple = '0;
        case (ctl)
            ALU_AND:  w_simple = a & b;
            ALU_OR:   w_simple = a | b;
            ALU_ADD:  w_simple = a + b;
            ALU_SUB:  w_simple = a - b;
            ALU_SLT:  w_simple = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_simple = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  w_simple = '0;
        endcase
    end

    assign w_mode = (r_state == S_DIV) ? MD_DIV : MD_MUL;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .i_mode       (w_mode),
        .i_acc        (r_acc),
        .i_shreg      (r_shreg),
        .i_opnd       (r_opnd),
        .o_acc_next   (w_acc_next),
        .o_shreg_next (w_shreg_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_shreg <= '0;
            r_opnd  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_zero  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (ctl == ALU_MULTU) begin
                            r_state <= S_MUL;
                            r_acc   <= '0;
                            r_shreg <= a;
                            r_opnd  <= b;
                        end else if (ctl == ALU_DIVU && b != '0) begin
                            r_state <= S_DIV;
                            r_acc   <= '0;
                            r_shreg <= a;
                            r_opnd  <= b;
                        end else if (ctl == ALU_DIVU) begin
                            // Divide by zero finishes at once with a MIPS-like saturated quotient.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hi    <= a;
                            r_lo    <= '1;
                            r_zero  <= 1'b0;
                            r_div0  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hi    <= '0;
                            r_lo    <= w_simple;
                            r_zero  <= (w_simple == '0);
                            r_div0  <= 1'b0;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc   <= w_acc_next;
                    r_shreg <= w_shreg_next;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_hi    <= w_acc_next;
                        r_lo    <= w_shreg_next;
                        r_zero  <= (w_shreg_next == '0);
                        r_div0  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign zero = r_zero;
    assign div0 = r_div0;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32: results, busy/done timing every cycle,
// ignored starts, and asynchronous reset mid-divide.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             div0;

    int compared   = 0;
    int mismatched = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ctl   (ctl),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .zero  (zero),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB);
        @(negedge clk);
        ctl   = c;
        a     = opA;
        b     = opB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one op, checking busy/done each cycle up to the expected latency, then results,
    // then that the block returns to idle and the results hold.
    task automatic runOp(input string tag, input logic [3:0] c, input logic [WIDTH-1:0] opA,
                         input logic [WIDTH-1:0] opB, input int lat, input logic [WIDTH-1:0] expHi,
                         input logic [WIDTH-1:0] expLo, input logic expZero, input logic expDiv0,
                         input int interruptAt, input logic startInDone);
        applyStimulus(c, opA, opB);
        for (int n = 1; n <= lat; n++) begin
            checkOutput({tag, " busy"}, 64'(busy), 64'd1);
            checkOutput({tag, " done"}, 64'(done), 64'(n == lat));
            if (n == 1) begin
                a = ~opA;
                b = opB + 3;
            end
            if (n == interruptAt) begin
                ctl   = ALU_ADD;
                a     = 1;
                b     = 2;
                start = 1'b1;
            end
            if (n == interruptAt + 1) start = 1'b0;
            if (n == lat && startInDone) begin
                ctl   = ALU_OR;
                a     = 32'h1;
                b     = 32'h2;
                start = 1'b1;
            end
            if (n < lat) @(negedge clk);
        end
        checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, " zero"}, 64'(zero), 64'(expZero));
        checkOutput({tag, " div0"}, 64'(div0), 64'(expDiv0));
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " idle done"}, 64'(done), 64'd0);
        @(negedge clk);
        checkOutput({tag, " hold busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " hold lo"}, 64'(lo), 64'(expLo));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ctl   = 4'b0000;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset zero", 64'(zero), 64'd0);
        checkOutput("reset div0", 64'(div0), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        runOp("add wrap", ALU_ADD, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        runOp("slt", ALU_SLT, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        runOp("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        runOp("multu max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
        runOp("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1'b0, 0, 1'b0);
        runOp("divu by 0", ALU_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 1'b0);
        runOp("sub wrap", ALU_SUB, 32'd5, 32'd7, 1, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 0, 1'b0);
        runOp("multu intr", ALU_MULTU, 32'h12345678, 32'h10, 33, 32'h1, 32'h23456780, 1'b0, 1'b0, 5, 1'b1);
        runOp("undef op", 4'b0011, 32'hDEADBEEF, 32'h1234, 1, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        runOp("or", ALU_OR, 32'hA0, 32'h0B, 1, 32'h0, 32'hAB, 1'b0, 1'b0, 0, 1'b1);
        runOp("divu big", ALU_DIVU, 32'hFFFFFFFF, 32'h10, 33, 32'hF, 32'h0FFFFFFF, 1'b0, 1'b0, 0, 1'b0);
        runOp("divu small", ALU_DIVU, 32'd3, 32'd9, 33, 32'd3, 32'd0, 1'b1, 1'b0, 0, 1'b0);
        runOp("multu zero", ALU_MULTU, 32'h0, 32'hCAFEF00D, 33, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0);

        // Abandon a divide part way through with an asynchronous reset.
        applyStimulus(ALU_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset done", 64'(done), 64'd0);
        checkOutput("mid reset lo", 64'(lo), 64'd0);
        checkOutput("mid reset hi", 64'(hi), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checkOutput("post reset done", 64'(done), 64'd0);
            checkOutput("post reset busy", 64'(busy), 64'd0);
        end
        runOp("and", ALU_AND, 32'hF0, 32'h3C, 1, 32'h0, 32'h30, 1'b0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
